datamover_engine: RTL
=====================

// Module: datamover_engine
// PURPOSE
//   Compute stage between the streamer's load and store streams. Consumes the data_in
//   HWPE-Stream produced by the streamer's HCI source and forwards a length-bounded job
//   through an internal FIFO. Produces the data_out stream drained by the streamer's HCI sink.
//   Counts beats, signals job completion, optionally accumulates a checksum.
// PARAMETERS
//   DW          32  stream data width in bits (multiple of 32); strb width is DW/8
//   FIFO_DEPTH  4   internal FIFO entries; power of 2, >= 2
//   CNT_W       32  width of len_i and beat_cnt_o
// PORTS
//   clk_i        in   1       clock
//   rst_i        in   1       reset; asynchronous, active-high
//   clear_i      in   1       synchronous soft clear
//   enable_i     in   1       input-side enable
//   start_i      in   1       job start strobe
//   len_i        in   CNT_W   job length in beats, sampled on accepted start
//   data_in      sink   DW    hwpe_stream_intf_stream (data/strb/valid/ready) from HCI source
//   data_out     source DW    hwpe_stream_intf_stream to HCI sink
//   busy_o       out  1       job in progress (state != IDLE)
//   done_o       out  1       one-cycle completion pulse
//   beat_cnt_o   out  CNT_W   beats handed over on data_out in current or last job
//   checksum_o   out  32      running checksum (0 when feature compiled out)
// BEHAVIOUR
//   Reset (rst_i high, async): state IDLE, FIFO empty. data_in.ready=0, data_out.valid=0.
//     data_out.data/strb=0, busy_o=0, done_o=0, beat_cnt_o=0, checksum_o=0.
//   clear_i (sync, priority over all else): same values as reset, next cycle.
//     In-flight beats in the FIFO are dropped. No done pulse is generated.
//   FSM: IDLE -> RUN   on start_i with len_i!=0. Latch len, zero accepted count, beat_cnt_o, checksum.
//        IDLE -> DONE  on start_i with len_i==0.
//        RUN  -> DRAIN when accepted count reaches latched len (cycle after last accept).
//        DRAIN-> DONE  when FIFO empty and no beat pending on data_out.
//        DONE -> IDLE  unconditionally. done_o=1 only in DONE.
//   start_i outside IDLE is ignored. len_i is not re-sampled.
//   Input: data_in.ready = (state==RUN) & enable_i & !full & (accepted<len).
//     Accept = valid & ready. Push data and strb unmodified.
//     No push when full; a pop in the same cycle does not free the slot combinationally.
//   Output: data_out.valid = !empty. data/strb = FIFO head, registered.
//     Beat accepted at cycle t is offered no earlier than t+1.
//     Pop on data_out.valid & ready. beat_cnt_o increments per pop and saturates at 2^CNT_W-1.
//     data_out is independent of enable_i. Once valid rises, data/strb stay stable until the pop.
//   Simultaneous push+pop when not full: occupancy unchanged, order preserved.
//   Pointers wrap modulo FIFO_DEPTH. Separate full/empty tracking (occupancy counter, 0..DEPTH).
//   Beats arriving after len reached are not accepted (ready stays 0); upstream holds them.
// CONFIGURATION
//   DATAMOVER_ENGINE_CHECKSUM_EN defined:
//     On each data_out pop, checksum_o <= checksum_o ^ (XOR of all DW/32 32-bit words of the
//     popped data). Strobes are ignored. Value is held after DONE until the next start or clear.
//   Not defined: no checksum logic; checksum_o tied to 32'h0.
// TESTING
//   1 len=4, data 1,2,3,4, out ready=1 -> data_out 1,2,3,4 in order, beat_cnt_o=4.
//     done_o high exactly 1 cycle, then busy_o=0.
//   2 len=8, out ready=0 -> data_in.ready drops after FIFO_DEPTH(4) accepts.
//     Raise ready -> all 8 beats out in order; no loss, no duplication.
//   3 len=0 start -> busy_o=1 one cycle (DONE), done_o pulse. No data_in.ready assertion.
//   4 len=3, source offers 5 beats -> only 3 accepted, 4th held with ready=0. done_o after drain.
//   5 clear_i mid-job, 2 beats in FIFO -> next cycle valid=0, busy_o=0, beat_cnt_o=0, no done_o.
//     New start then works.
//   6 CHECKSUM_EN, DW=64, beats 64'h1_00000002 and 64'h4_00000008 -> checksum_o=32'h0000000F.
//     Without macro -> 0.

Source files
------------

// File: rtl/datamover_engine_if.sv
// Valid/ready stream bundle (data + byte strobes) used on both sides of datamover_engine.
interface datamover_engine_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            valid;
    logic            ready;

    modport master (output data, strb, valid, input ready);
    modport slave  (input data, strb, valid, output ready);
endinterface

// File: rtl/datamover_engine.sv
// Length-bounded stream forwarder: accepts len_i beats into a small FIFO, drains them to data_out.
// Optional XOR checksum of drained data when DATAMOVER_ENGINE_CHECKSUM_EN is defined.
module datamover_engine #(
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     len_i,
    datamover_engine_if.slave    data_in,
    datamover_engine_if.master   data_out,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     beat_cnt_o,
    output logic [31:0]          checksum_o
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_nxt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [DW-1:0]    data_mem [FIFO_DEPTH];
    logic [SW-1:0]    strb_mem [FIFO_DEPTH];
    logic [DW-1:0]    head_data;
    logic [SW-1:0]    head_strb;

    assign full    = (occ == OW'(FIFO_DEPTH));
    assign empty   = (occ == '0);
    assign push    = data_in.valid & data_in.ready;
    assign pop     = data_out.valid & data_out.ready;
    assign acc_nxt = acc_cnt + CNT_W'(push);

    // Input stage: accept only while running, enabled, with room and beats still owed.
    assign data_in.ready = (state == RUN) & enable_i & ~full & (acc_cnt < len_q);

    // Storage stage: a beat written at one edge is visible as the head only afterwards.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr] <= data_in.data;
            strb_mem[wr_ptr] <= data_in.strb;
        end
    end

    // Output stage: head entry is held in registers and never rewritten while occupied.
    assign head_data      = data_mem[rd_ptr];
    assign head_strb      = strb_mem[rd_ptr];
    assign data_out.valid = ~empty;
    assign data_out.data  = empty ? '0 : head_data;
    assign data_out.strb  = empty ? '0 : head_strb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            len_q      <= '0;
            acc_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            beat_cnt_o <= '0;
        end else if (clear_i) begin
            state      <= IDLE;
            len_q      <= '0;
            acc_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            beat_cnt_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: ;
            endcase
            if (pop) beat_cnt_o <= sat_inc(beat_cnt_o);
            done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q      <= len_i;
                        acc_cnt    <= '0;
                        beat_cnt_o <= '0;
                        busy_o     <= 1'b1;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_cnt <= acc_nxt;
                    // Leave RUN in the cycle right after the final accept.
                    if (acc_nxt == len_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (empty) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATAMOVER_ENGINE_CHECKSUM_EN
    function automatic logic [31:0] fold_words(input logic [DW-1:0] d);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < int'(DW / 32); i++) acc = acc ^ d[i*32 +: 32];
        return acc;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            checksum_o <= '0;
        end else if (clear_i) begin
            checksum_o <= '0;
        end else if ((state == IDLE) && start_i) begin
            checksum_o <= '0;
        end else if (pop) begin
            checksum_o <= checksum_o ^ fold_words(head_data);
        end
    end
`else
    assign checksum_o = 32'h0;
`endif

endmodule
